gp_dense_sequencer: RTL
=======================

Name: gp_dense_sequencer

Overview:
- Compute-side controller behind the generic AXI-stream interface; owns the axisif_* wrapper handshake.
- On a start edge it runs one fully-connected layer slice. It reads IN_DATA_NUM activations from the interface input buffer and weights from an external weight ROM, with an internal signed MAC.
- Writes OUT_DATA_NUM results into the interface output buffer, then raises done.
- Used once per dense layer of the MNIST CNN; the interface streams results out after done.

Parameters:
- DATA_WIDTH, 32, activation/weight/result width (signed two's complement).
- IN_DATA_NUM, 8, inputs per output neuron.
- OUT_DATA_NUM, 4, output neurons per run.
- IN_ADR_WIDTH, 3, clog2(IN_DATA_NUM).
- OUT_ADR_WIDTH, 2, clog2(OUT_DATA_NUM).
- W_ADR_WIDTH, 5, clog2(IN_DATA_NUM*OUT_DATA_NUM).
- FRAC_BITS, 0, arithmetic right shift applied to the accumulator before output.
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- axisif_start, in, 1, run request from the interface; rising edge triggers a run.
- axisif_done, out, 1, high when idle or finished; low while running.
- axisif_bufferIn_adr, out, IN_ADR_WIDTH, input buffer read address.
- axisif_bufferIn_data, in, DATA_WIDTH, input buffer data; combinational read of the current address.
- w_adr, out, W_ADR_WIDTH, weight ROM address = out_idx*IN_DATA_NUM + in_idx.
- w_data, in, DATA_WIDTH, weight data; combinational read.
- axisif_bufferOut_adr, out, OUT_ADR_WIDTH, output buffer write address.
- axisif_bufferOut_data, out, DATA_WIDTH, output buffer write data.
- axisif_bufferOut_wr, out, 1, output buffer write strobe, one cycle per result.

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE; done=1; wr=0; all addresses=0; bufferOut_data=0; acc=0; in_idx=0; out_idx=0.
  - start_q=1, so a start held high across reset does not trigger a run.
- Start detection:
  - start_q registers axisif_start every cycle.
  - Trigger = start & ~start_q while state=IDLE.
  - Start edges in any other state are ignored and not queued.
- FSM states: IDLE, CLEAR, ACC, WRITE.
- IDLE:
  - done=1, wr=0.
  - On trigger: go to CLEAR, out_idx<=0, done<=0. done is low from the next cycle.
- CLEAR (1 cycle): acc<=0, in_idx<=0, then go to ACC.
- ACC (IN_DATA_NUM cycles):
  - bufferIn_adr=in_idx; w_adr=out_idx*IN_DATA_NUM+in_idx.
  - acc<=acc+sext(bufferIn_data)*sext(w_data), with a full 2*DATA_WIDTH signed product and a 2*DATA_WIDTH+IN_ADR_WIDTH accumulator (no overflow possible).
  - in_idx++ each cycle; when in_idx==IN_DATA_NUM-1, go to WRITE after this accumulate.
- WRITE (1 cycle):
  - wr=1, bufferOut_adr=out_idx, bufferOut_data=post(acc).
  - If out_idx==OUT_DATA_NUM-1: go to IDLE, done<=1.
  - Else: out_idx++, go to CLEAR.
- post(acc) steps, in order:
  - Arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If RELU_EN, values <0 become 0.
- Latency:
  - Trigger sampled at cycle 0; writes occur at cycles k*(IN_DATA_NUM+2)+IN_DATA_NUM+2 for k=0..OUT_DATA_NUM-1.
  - done rises at cycle OUT_DATA_NUM*(IN_DATA_NUM+2)+1. Defaults: writes at 10, 20, 30, 40; done at 41.
- wr is high only in WRITE; addresses hold their last value outside ACC/WRITE.
- Reset mid-run aborts immediately: no further writes, done=1 on the cycle after reset is sampled.
- Start rising on the same cycle done returns to 1: not a trigger. The state is still WRITE on that edge; the edge is lost and start must fall and rise again.

Test Plan:
- Inputs 1..8, all weights 1, defaults -> four writes, adr 0..3, data 36 each, at cycles 10/20/30/40 after trigger; done low cycles 1..40, high at 41.
- Inputs 1..8, weights w[o][i]=o+1 -> data 36, 72, 108, 144 at adr 0, 1, 2, 3.
- Inputs 1..8, weights for o=1 all -1, RELU_EN=1 -> adr1 data 0; with RELU_EN=0 -> adr1 data -36 (0xFFFFFFDC).
- DATA_WIDTH=8, inputs 127, weights 127 -> every output saturates to 127. Same with weights -128, RELU_EN=0 -> -128. FRAC_BITS=4, inputs 16, weights 16, DATA_WIDTH=32 -> 128 each.
- axisif_start held high 100 cycles -> exactly one run (4 writes). Extra start pulse mid-run -> ignored, no second run. Start toggled again after done -> second identical run.
- rst pulsed at cycle 15 of a run -> only the adr0 write occurred, wr=0 thereafter, done=1 at cycle 16. A new start edge afterward -> full correct run.

Source files
------------

// File: rtl/gp_dense_sequencer.sv
// gp_dense_sequencer: dense-layer MAC sequencer that owns the axisif buffer handshake
module gp_dense_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int IN_DATA_NUM   = 8,
    parameter int OUT_DATA_NUM  = 4,
    parameter int IN_ADR_WIDTH  = 3,
    parameter int OUT_ADR_WIDTH = 2,
    parameter int W_ADR_WIDTH   = 5,
    parameter int FRAC_BITS     = 0,
    parameter int RELU_EN       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     axisif_start,
    output logic                     axisif_done,
    output logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
    input  logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
    output logic [W_ADR_WIDTH-1:0]   w_adr,
    input  logic [DATA_WIDTH-1:0]    w_data,
    output logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
    output logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
    output logic                     axisif_bufferOut_wr
);
    localparam int ACC_W = 2 * DATA_WIDTH + IN_ADR_WIDTH;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CLEAR, ACC, WRITE} state_t;

    state_t                         state, state_nx;
    logic                           start_q, done_q, trigger, last_in, last_out;
    logic [IN_ADR_WIDTH-1:0]        in_idx;
    logic [OUT_ADR_WIDTH-1:0]       out_idx;
    logic signed [2*DATA_WIDTH-1:0] a_ext, w_ext, prod;
    logic signed [ACC_W-1:0]        acc, shifted;
    logic [DATA_WIDTH-1:0]          sat, result;

    assign trigger  = axisif_start && !start_q && state == IDLE;
    assign last_in  = in_idx == IN_ADR_WIDTH'(IN_DATA_NUM - 1);
    assign last_out = out_idx == OUT_ADR_WIDTH'(OUT_DATA_NUM - 1);
    assign a_ext    = {{DATA_WIDTH{axisif_bufferIn_data[DATA_WIDTH-1]}}, axisif_bufferIn_data};
    assign w_ext    = {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};
    assign prod     = a_ext * w_ext;
    assign shifted  = acc >>> FRAC_BITS;
    assign sat      = shifted > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] :
                      shifted < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign result   = (RELU_EN != 0 && sat[DATA_WIDTH-1]) ? '0 : sat;

    assign axisif_done           = done_q;
    assign axisif_bufferIn_adr   = in_idx;
    assign w_adr                 = W_ADR_WIDTH'(out_idx) * W_ADR_WIDTH'(IN_DATA_NUM) + W_ADR_WIDTH'(in_idx);
    assign axisif_bufferOut_adr  = out_idx;
    assign axisif_bufferOut_wr   = state == WRITE;
    assign axisif_bufferOut_data = axisif_bufferOut_wr ? result : '0;

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // next state: IDLE -> (CLEAR -> ACC x IN_DATA_NUM -> WRITE) x OUT_DATA_NUM -> IDLE
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (trigger ? CLEAR : IDLE) :
                   state == CLEAR ? ACC :
                   state == ACC   ? (last_in ? WRITE : ACC) :
                                    (last_out ? IDLE : CLEAR);
    end

    // start edge history, counters, accumulator and done flag; in_idx parks on the last input
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            done_q  <= 1'b1;
            acc     <= '0;
            in_idx  <= '0;
            out_idx <= '0;
        end else begin
            start_q <= axisif_start;
            if (trigger) begin
                out_idx <= '0;
                done_q  <= 1'b0;
            end
            if (state == CLEAR) begin
                acc    <= '0;
                in_idx <= '0;
            end
            if (state == ACC) begin
                acc <= acc + {{IN_ADR_WIDTH{prod[2*DATA_WIDTH-1]}}, prod};
                if (!last_in)
                    in_idx <= in_idx + IN_ADR_WIDTH'(1);
            end
            if (state == WRITE) begin
                if (last_out)
                    done_q <= 1'b1;
                else
                    out_idx <= out_idx + OUT_ADR_WIDTH'(1);
            end
        end
    end
endmodule
